alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
- REQ-001 SHALL have parameter DATA_W, default 16, meaning ALU result and register-file write-data width.
- REQ-002 SHALL have parameter REG_ADDR_W, default 3, meaning register index width (8 registers).
- REQ-003 SHALL have port i_clk  in  1  the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port i_rst  in  1  reset, asynchronous and active-high.
- REQ-005 SHALL have port i_valid  in  1  ALU result valid; presented one cycle after the ALU opcode was issued.
- REQ-006 SHALL have port o_ready  out  1  block can accept a result this cycle.
- REQ-007 SHALL have port i_result  in  DATA_W  registered ALU result.
- REQ-008 SHALL have port i_flags  in  4  {carry, overflow, sign, zero} from the ALU, bits [3:0] = C,V,S,Z.
- REQ-009 SHALL have port i_rd  in  REG_ADDR_W  destination register index.
- REQ-010 SHALL have port i_flags_we  in  1  update the architectural flags with i_flags.
- REQ-011 SHALL have port o_rf_we  out  1  register-file write request.
- REQ-012 SHALL have port i_rf_ready  in  1  register-file write port grant.
- REQ-013 SHALL have port o_rf_waddr  out  REG_ADDR_W  write index.
- REQ-014 SHALL have port o_rf_wdata  out  DATA_W  write data.
- REQ-015 SHALL have port o_flags  out  4  architectural flags register, same bit order as i_flags.
- REQ-016 SHALL have port o_retired  out  16  count of completed register-file writes.

Function
- REQ-017 SHALL accept a result when i_valid && o_ready (a "push").
- REQ-018 SHALL buffer pending writes in a 2-entry FIFO; occupancy states EMPTY(0), ONE(1), FULL(2).
- REQ-019 SHALL drive o_ready = (occupancy != FULL), registered-state only, with no combinational path from i_rf_ready.
- REQ-020 SHALL discard a push with i_rd == 0 (r0 hardwired zero): no FIFO entry, with the flags update still applied.
- REQ-021 SHALL drive o_rf_we = (occupancy != EMPTY), with o_rf_waddr/o_rf_wdata taken from the FIFO head, stable while o_rf_we && !i_rf_ready.
- REQ-022 SHALL pop the head on o_rf_we && i_rf_ready and increment o_retired, wrapping 0xFFFF -> 0x0000.
- REQ-023 SHALL leave occupancy unchanged on a simultaneous push and pop, in FIFO order.
- REQ-024 SHALL set push-to-o_rf_we latency to 1 cycle from EMPTY.
- REQ-025 SHALL load o_flags with i_flags on the cycle after a push with i_flags_we=1, independent of FIFO state; o_flags is otherwise held.
- REQ-026 SHALL ignore i_valid while o_ready=0, with no state change.

Reset
- REQ-027 SHALL on i_rst clear occupancy to EMPTY, o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, o_flags=0, o_retired=0, and o_ready=1 after release.
- REQ-028 SHALL discard pending entries on reset mid-operation, with no write issued for them.

Configuration
- REQ-029 SHALL, when ALU_WB_FWD_EN is defined, add outputs o_fwd_hit (1), o_fwd_data (DATA_W) and input i_fwd_rs (REG_ADDR_W).
- REQ-030 SHALL, with ALU_WB_FWD_EN defined, assert o_fwd_hit combinationally when i_fwd_rs != 0 and matches a valid entry, with o_fwd_data taken from the youngest matching entry.
- REQ-031 SHALL, without ALU_WB_FWD_EN, omit these ports and their logic entirely.

Structure
- REQ-032 SHALL take flag bit positions (FLAG_Z=0, FLAG_S=1, FLAG_V=2, FLAG_C=3) and default widths from shared package argon_pkg.
- REQ-033 SHALL implement the FIFO as sub-module wb_fifo2 (2 entries, push/pop/occupancy, entry visibility for forwarding).

Verification
- REQ-034 SHALL cover: push rd=3, data 0x1234, i_rf_ready=1 -> o_rf_we=1 next cycle with waddr 3, wdata 0x1234; o_retired=1 after.
- REQ-035 SHALL cover: i_rf_ready=0, push 0xAAAA then 0xBBBB -> o_ready=0; a third push is ignored; on release, writes are 0xAAAA then 0xBBBB in order.
- REQ-036 SHALL cover: push rd=0, flags_we=1, flags=4'b0001 -> no o_rf_we; o_flags=4'b0001 next cycle.
- REQ-037 SHALL cover: assert i_rst with occupancy FULL -> all outputs zero, no further writes, o_ready=1.
- REQ-038 SHALL cover: o_retired preloaded to 0xFFFF via 65535 writes, one more write -> o_retired=0x0000.
- REQ-039 SHALL cover, with ALU_WB_FWD_EN: two entries rd=5 (0x0001 older, 0x0002 younger), i_fwd_rs=5 -> o_fwd_hit=1, o_fwd_data=0x0002; i_fwd_rs=0 -> o_fwd_hit=0.

Source files
------------

// File: rtl/argon_pkg.sv
// Shared widths, flag bit positions and the writeback FIFO occupancy encoding.
package argon_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int REG_ADDR_W_DEF = 3;
  localparam int FLAGS_W        = 4;
  localparam int RETIRED_W      = 16;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Repack a raw ALU flag nibble through the named bit positions.
  function automatic logic [FLAGS_W-1:0] pack_flags(input logic [FLAGS_W-1:0] raw);
    logic [FLAGS_W-1:0] f;
    f         = '0;
    f[FLAG_Z] = raw[FLAG_Z];
    f[FLAG_S] = raw[FLAG_S];
    f[FLAG_V] = raw[FLAG_V];
    f[FLAG_C] = raw[FLAG_C];
    return f;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Handshake/bus bundle between the ALU, alu_writeback and the register file.
// Forwarding signals exist only when ALU_WB_FWD_EN is defined.
interface alu_writeback_if
  import argon_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
);

  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_W-1:0]     i_result;
  logic [FLAGS_W-1:0]    i_flags;
  logic [REG_ADDR_W-1:0] i_rd;
  logic                  i_flags_we;
  logic                  o_rf_we;
  logic                  i_rf_ready;
  logic [REG_ADDR_W-1:0] o_rf_waddr;
  logic [DATA_W-1:0]     o_rf_wdata;
  logic [FLAGS_W-1:0]    o_flags;
  logic [RETIRED_W-1:0]  o_retired;
`ifdef ALU_WB_FWD_EN
  logic                  o_fwd_hit;
  logic [DATA_W-1:0]     o_fwd_data;
  logic [REG_ADDR_W-1:0] i_fwd_rs;
`endif

  modport master (
    output i_valid, i_result, i_flags, i_rd, i_flags_we, i_rf_ready,
`ifdef ALU_WB_FWD_EN
    output i_fwd_rs,
    input  o_fwd_hit, o_fwd_data,
`endif
    input  o_ready, o_rf_we, o_rf_waddr, o_rf_wdata, o_flags, o_retired
  );

  modport slave (
    input  i_valid, i_result, i_flags, i_rd, i_flags_we, i_rf_ready,
`ifdef ALU_WB_FWD_EN
    input  i_fwd_rs,
    output o_fwd_hit, o_fwd_data,
`endif
    output o_ready, o_rf_we, o_rf_waddr, o_rf_wdata, o_flags, o_retired
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry shift FIFO of pending register writes; entry 0 is always the head.
// The younger entry is exported only when ALU_WB_FWD_EN is defined.
module wb_fifo2
  import argon_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0]     push_data,
  output occ_e                  occ,
  output logic [REG_ADDR_W-1:0] head_rd,
  output logic [DATA_W-1:0]     head_data
`ifdef ALU_WB_FWD_EN
  ,
  output logic [REG_ADDR_W-1:0] tail_rd,
  output logic [DATA_W-1:0]     tail_data
`endif
);

  occ_e                  occ_next;
  logic [REG_ADDR_W-1:0] rd0, rd1;
  logic [DATA_W-1:0]     data0, data1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ <= OCC_EMPTY;
    else     occ <= occ_next;
  end

  // The owner never pushes when FULL nor pops when EMPTY.
  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = (occ == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_next = (occ == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0   <= '0;
      rd1   <= '0;
      data0 <= '0;
      data1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == OCC_EMPTY) begin
            rd0   <= push_rd;
            data0 <= push_data;
          end else begin
            rd1   <= push_rd;
            data1 <= push_data;
          end
        end
        2'b01: begin
          rd0   <= rd1;
          data0 <= data1;
        end
        2'b11: begin
          if (occ == OCC_FULL) begin
            rd0   <= rd1;
            data0 <= data1;
            rd1   <= push_rd;
            data1 <= push_data;
          end else begin
            rd0   <= push_rd;
            data0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_rd   = rd0;
  assign head_data = data0;
`ifdef ALU_WB_FWD_EN
  assign tail_rd   = rd1;
  assign tail_data = data1;
`endif

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers results for the register file, tracks flags and retired count.
// Define ALU_WB_FWD_EN to add operand forwarding from the pending-write FIFO.
module alu_writeback
  import argon_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  alu_writeback_if.slave bus
);

  occ_e                  occ;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0]     head_data;
  logic                  accept;
  logic                  fifo_push;
  logic                  fifo_pop;
`ifdef ALU_WB_FWD_EN
  logic [REG_ADDR_W-1:0] tail_rd;
  logic [DATA_W-1:0]     tail_data;
  logic                  head_hit;
  logic                  tail_hit;
`endif

  // r0 writes are dropped here so they never occupy a FIFO slot.
  assign accept    = bus.i_valid && bus.o_ready;
  assign fifo_push = accept && (bus.i_rd != '0);
  assign fifo_pop  = bus.o_rf_we && bus.i_rf_ready;

  wb_fifo2 #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_rd   (bus.i_rd),
    .push_data (bus.i_result),
    .occ       (occ),
    .head_rd   (head_rd),
    .head_data (head_data)
`ifdef ALU_WB_FWD_EN
    ,
    .tail_rd   (tail_rd),
    .tail_data (tail_data)
`endif
  );

  assign bus.o_ready    = (occ != OCC_FULL);
  assign bus.o_rf_we    = (occ != OCC_EMPTY);
  assign bus.o_rf_waddr = head_rd;
  assign bus.o_rf_wdata = head_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_flags   <= '0;
      bus.o_retired <= '0;
    end else begin
      if (accept && bus.i_flags_we) bus.o_flags <= pack_flags(bus.i_flags);
      if (fifo_pop) bus.o_retired <= bus.o_retired + 16'd1;
    end
  end

`ifdef ALU_WB_FWD_EN
  // The younger entry wins when both slots target the same register.
  assign head_hit       = (occ != OCC_EMPTY) && (head_rd == bus.i_fwd_rs);
  assign tail_hit       = (occ == OCC_FULL) && (tail_rd == bus.i_fwd_rs);
  assign bus.o_fwd_hit  = (bus.i_fwd_rs != '0) && (head_hit || tail_hit);
  assign bus.o_fwd_data = tail_hit ? tail_data : head_data;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback (forwarding steps run when ALU_WB_FWD_EN is defined).
module tb_alu_writeback;
  import argon_pkg::*;

  logic i_clk;
  logic i_rst;
  int   tests;
  int   failed;

  alu_writeback_if #(.DATA_W(16), .REG_ADDR_W(3)) bus ();

  alu_writeback #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] rd, input logic [15:0] result,
                               input logic flags_we, input logic [3:0] flags);
    bus.i_valid    = valid;
    bus.i_rd       = rd;
    bus.i_result   = result;
    bus.i_flags_we = flags_we;
    bus.i_flags    = flags;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    i_rst  = 1'b1;
    bus.i_rf_ready = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
`ifdef ALU_WB_FWD_EN
    bus.i_fwd_rs = 3'd0;
`endif
    tick();
    tick();
    checkOutput("reset_rf_we", {31'd0, bus.o_rf_we}, 32'd0);
    checkOutput("reset_flags", {28'd0, bus.o_flags}, 32'd0);
    checkOutput("reset_retired", {16'd0, bus.o_retired}, 32'd0);
    checkOutput("reset_ready", {31'd0, bus.o_ready}, 32'd1);
    i_rst = 1'b0;

    // single write, granted immediately
    bus.i_rf_ready = 1'b1;
    applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, 4'h0);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    checkOutput("t1_rf_we", {31'd0, bus.o_rf_we}, 32'd1);
    checkOutput("t1_waddr", {29'd0, bus.o_rf_waddr}, 32'd3);
    checkOutput("t1_wdata", {16'd0, bus.o_rf_wdata}, 32'h1234);
    checkOutput("t1_retired_before", {16'd0, bus.o_retired}, 32'd0);
    tick();
    checkOutput("t1_rf_we_after", {31'd0, bus.o_rf_we}, 32'd0);
    checkOutput("t1_retired_after", {16'd0, bus.o_retired}, 32'd1);

    // backpressure: fill, ignored third push, ordered drain
    bus.i_rf_ready = 1'b0;
    applyStimulus(1'b1, 3'd1, 16'hAAAA, 1'b0, 4'h0);
    tick();
    applyStimulus(1'b1, 3'd2, 16'hBBBB, 1'b0, 4'h0);
    tick();
    checkOutput("t2_ready_full", {31'd0, bus.o_ready}, 32'd0);
    checkOutput("t2_head_data", {16'd0, bus.o_rf_wdata}, 32'hAAAA);
    applyStimulus(1'b1, 3'd4, 16'hCCCC, 1'b1, 4'hF);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    checkOutput("t2_ignored_head", {16'd0, bus.o_rf_wdata}, 32'hAAAA);
    checkOutput("t2_ignored_waddr", {29'd0, bus.o_rf_waddr}, 32'd1);
    checkOutput("t2_ignored_flags", {28'd0, bus.o_flags}, 32'd0);
    checkOutput("t2_held_we", {31'd0, bus.o_rf_we}, 32'd1);
    bus.i_rf_ready = 1'b1;
    tick();
    checkOutput("t2_second_data", {16'd0, bus.o_rf_wdata}, 32'hBBBB);
    checkOutput("t2_second_waddr", {29'd0, bus.o_rf_waddr}, 32'd2);
    checkOutput("t2_ready_again", {31'd0, bus.o_ready}, 32'd1);
    checkOutput("t2_retired_mid", {16'd0, bus.o_retired}, 32'd2);
    tick();
    checkOutput("t2_drained", {31'd0, bus.o_rf_we}, 32'd0);
    checkOutput("t2_retired_end", {16'd0, bus.o_retired}, 32'd3);

    // simultaneous push and pop keeps one entry
    applyStimulus(1'b1, 3'd6, 16'h0606, 1'b0, 4'h0);
    tick();
    applyStimulus(1'b1, 3'd7, 16'h0707, 1'b0, 4'h0);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    checkOutput("t3_head_data", {16'd0, bus.o_rf_wdata}, 32'h0707);
    checkOutput("t3_waddr", {29'd0, bus.o_rf_waddr}, 32'd7);
    checkOutput("t3_retired", {16'd0, bus.o_retired}, 32'd4);
    tick();
    checkOutput("t3_empty", {31'd0, bus.o_rf_we}, 32'd0);
    checkOutput("t3_retired_end", {16'd0, bus.o_retired}, 32'd5);

    // r0 push only updates flags; flags hold without a push
    applyStimulus(1'b1, 3'd0, 16'hDEAD, 1'b1, 4'b0001);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 4'b1010);
    checkOutput("t4_no_write", {31'd0, bus.o_rf_we}, 32'd0);
    checkOutput("t4_flags", {28'd0, bus.o_flags}, 32'b0001);
    tick();
    checkOutput("t4_flags_held", {28'd0, bus.o_flags}, 32'b0001);
    checkOutput("t4_retired", {16'd0, bus.o_retired}, 32'd5);
    applyStimulus(1'b1, 3'd5, 16'h5555, 1'b1, 4'b1100);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    checkOutput("t4_flags_with_write", {28'd0, bus.o_flags}, 32'b1100);
    tick();

`ifdef ALU_WB_FWD_EN
    bus.i_rf_ready = 1'b0;
    applyStimulus(1'b1, 3'd5, 16'h0001, 1'b0, 4'h0);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    bus.i_fwd_rs = 3'd5;
    #1;
    checkOutput("fwd_one_hit", {31'd0, bus.o_fwd_hit}, 32'd1);
    checkOutput("fwd_one_data", {16'd0, bus.o_fwd_data}, 32'h0001);
    applyStimulus(1'b1, 3'd5, 16'h0002, 1'b0, 4'h0);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    checkOutput("fwd_two_hit", {31'd0, bus.o_fwd_hit}, 32'd1);
    checkOutput("fwd_youngest", {16'd0, bus.o_fwd_data}, 32'h0002);
    bus.i_fwd_rs = 3'd0;
    #1;
    checkOutput("fwd_r0_miss", {31'd0, bus.o_fwd_hit}, 32'd0);
    bus.i_fwd_rs = 3'd3;
    #1;
    checkOutput("fwd_other_miss", {31'd0, bus.o_fwd_hit}, 32'd0);
    bus.i_fwd_rs = 3'd0;
    tick();
`else
    bus.i_rf_ready = 1'b0;
`endif

    // reset while FULL discards both entries
    applyStimulus(1'b1, 3'd1, 16'h1111, 1'b1, 4'b0110);
    tick();
    applyStimulus(1'b1, 3'd2, 16'h2222, 1'b0, 4'h0);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    checkOutput("t5_full", {31'd0, bus.o_ready}, 32'd0);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("t5_rst_we", {31'd0, bus.o_rf_we}, 32'd0);
    checkOutput("t5_rst_waddr", {29'd0, bus.o_rf_waddr}, 32'd0);
    checkOutput("t5_rst_wdata", {16'd0, bus.o_rf_wdata}, 32'd0);
    checkOutput("t5_rst_flags", {28'd0, bus.o_flags}, 32'd0);
    checkOutput("t5_rst_retired", {16'd0, bus.o_retired}, 32'd0);
    tick();
    i_rst = 1'b0;
    bus.i_rf_ready = 1'b1;
    tick();
    tick();
    checkOutput("t5_no_write", {31'd0, bus.o_rf_we}, 32'd0);
    checkOutput("t5_retired", {16'd0, bus.o_retired}, 32'd0);
    checkOutput("t5_ready", {31'd0, bus.o_ready}, 32'd1);

    // retired counter wraps after 65536 writes
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1'b1, 3'd1, i[15:0], 1'b0, 4'h0);
      tick();
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    tick();
    checkOutput("t6_retired_max", {16'd0, bus.o_retired}, 32'hFFFF);
    applyStimulus(1'b1, 3'd2, 16'h4242, 1'b0, 4'h0);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    checkOutput("t6_last_data", {16'd0, bus.o_rf_wdata}, 32'h4242);
    tick();
    checkOutput("t6_retired_wrap", {16'd0, bus.o_retired}, 32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
